// File: rtl/char_move_engine.sv
// char_move_engine: steps NUM_CHARS characters one tile per frame tick, querying an external wall map.
// Optional TUNNEL_WRAP_EN: horizontal moves off column 1 / GRID_W-1 wrap to the opposite edge.
module char_move_engine #(
    parameter int NUM_CHARS = 5,
    parameter int COORD_W   = 5,
    parameter int GRID_W    = 28,
    parameter int GRID_H    = 28,
    parameter int PLAYER_X0 = 2,
    parameter int PLAYER_Y0 = 2,
    parameter int GHOST_X0  = 27,
    parameter int GHOST_Y0  = 27
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick,
    input  logic [2*NUM_CHARS-1:0]       desired_dir,
    input  logic                         load_we,
    input  logic [2:0]                   load_idx,
    input  logic [COORD_W-1:0]           load_x,
    input  logic [COORD_W-1:0]           load_y,
    input  logic [1:0]                   load_dir,
    output logic                         map_req,
    output logic [COORD_W-1:0]           map_x,
    output logic [COORD_W-1:0]           map_y,
    input  logic                         map_wall,
    output logic [COORD_W*NUM_CHARS-1:0] pos_x,
    output logic [COORD_W*NUM_CHARS-1:0] pos_y,
    output logic [2*NUM_CHARS-1:0]       dir,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_CHARS-2:0]         collide_mask,
    output logic                         overrun
);

    // state    | meaning
    // IDLE     | waiting for tick; loads accepted
    // REQ_DES  | query tile in desired direction (skip query if out of bounds)
    // CHK_DES  | wall answer for desired tile; commit move + direction if free
    // REQ_CUR  | query tile in current direction
    // CHK_CUR  | wall answer for current tile; commit move if free
    // NEXT     | advance to next character or finish
    // COLL     | compare every ghost against the player's post-move tile
    // DONE     | one-cycle done pulse, drop busy
    typedef enum logic [2:0] {
        S_IDLE, S_REQ_DES, S_CHK_DES, S_REQ_CUR, S_CHK_CUR, S_NEXT, S_COLL, S_DONE
    } state_t;

    localparam int                 CW1      = COORD_W + 1;
    localparam logic [COORD_W:0]   C_ONE    = CW1'(1);
    localparam logic [COORD_W:0]   X_MAX    = CW1'(GRID_W - 1);
    localparam logic [COORD_W:0]   Y_MAX    = CW1'(GRID_H - 1);
    localparam logic [2:0]         LAST_IDX = 3'(NUM_CHARS - 1);
    localparam logic [COORD_W-1:0] P_X0     = COORD_W'(PLAYER_X0);
    localparam logic [COORD_W-1:0] P_Y0     = COORD_W'(PLAYER_Y0);
    localparam logic [COORD_W-1:0] G_X0     = COORD_W'(GHOST_X0);
    localparam logic [COORD_W-1:0] G_Y0     = COORD_W'(GHOST_Y0);

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;
    logic [NUM_CHARS-2:0]  collide_q, collide_d;
    logic [COORD_W-1:0]    tgt_x_q, tgt_x_d;
    logic [COORD_W-1:0]    tgt_y_q, tgt_y_d;
    logic [1:0]            cand_dir_q, cand_dir_d;
    logic [COORD_W-1:0]    pos_x_q [NUM_CHARS];
    logic [COORD_W-1:0]    pos_x_d [NUM_CHARS];
    logic [COORD_W-1:0]    pos_y_q [NUM_CHARS];
    logic [COORD_W-1:0]    pos_y_d [NUM_CHARS];
    logic [1:0]            dir_q   [NUM_CHARS];
    logic [1:0]            dir_d   [NUM_CHARS];

    logic [COORD_W-1:0]    cur_x, cur_y;
    logic [1:0]            cur_dir, des_dir, req_dir;
    logic [COORD_W:0]      ext_x, ext_y, cand_x, cand_y;
    logic                  cand_ok;

    always_comb begin
        cur_x   = '0;
        cur_y   = '0;
        cur_dir = '0;
        des_dir = '0;
        for (int i = 0; i < NUM_CHARS; i++) begin
            if (idx_q == 3'(i)) begin
                cur_x   = pos_x_q[i];
                cur_y   = pos_y_q[i];
                cur_dir = dir_q[i];
                des_dir = desired_dir[2*i +: 2];
            end
        end
    end

    // One extra bit lets 0-1 and max+1 land outside the valid window.
    always_comb begin
        req_dir = (state_q == S_REQ_CUR) ? cur_dir : des_dir;
        ext_x   = {1'b0, cur_x};
        ext_y   = {1'b0, cur_y};
        cand_x  = ext_x;
        cand_y  = ext_y;
        case (req_dir)
            2'd0: cand_y = ext_y - C_ONE;
            2'd1: cand_x = ext_x - C_ONE;
            2'd2: cand_y = ext_y + C_ONE;
            default: cand_x = ext_x + C_ONE;
        endcase
`ifdef TUNNEL_WRAP_EN
        if (req_dir == 2'd1 && ext_x == C_ONE) begin
            cand_x = X_MAX;
        end
        if (req_dir == 2'd3 && ext_x == X_MAX) begin
            cand_x = C_ONE;
        end
`endif
        cand_ok = (cand_x >= C_ONE) && (cand_x <= X_MAX) &&
                  (cand_y >= C_ONE) && (cand_y <= Y_MAX);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        overrun_d  = overrun_q | (tick & busy_q);
        collide_d  = collide_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        cand_dir_d = cand_dir_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        dir_d      = dir_q;
        map_req    = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_we) begin
                    for (int i = 0; i < NUM_CHARS; i++) begin
                        if (load_idx == 3'(i)) begin
                            pos_x_d[i] = load_x;
                            pos_y_d[i] = load_y;
                            dir_d[i]   = load_dir;
                        end
                    end
                end
                if (tick) begin
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_REQ_DES;
                end
            end
            S_REQ_DES, S_REQ_CUR: begin
                if (cand_ok) begin
                    map_req    = 1'b1;
                    tgt_x_d    = cand_x[COORD_W-1:0];
                    tgt_y_d    = cand_y[COORD_W-1:0];
                    cand_dir_d = req_dir;
                    state_d    = (state_q == S_REQ_DES) ? S_CHK_DES : S_CHK_CUR;
                end else begin
                    state_d    = (state_q == S_REQ_DES) ? S_REQ_CUR : S_NEXT;
                end
            end
            S_CHK_DES, S_CHK_CUR: begin
                if (!map_wall) begin
                    for (int i = 0; i < NUM_CHARS; i++) begin
                        if (idx_q == 3'(i)) begin
                            pos_x_d[i] = tgt_x_q;
                            pos_y_d[i] = tgt_y_q;
                            dir_d[i]   = cand_dir_q;
                        end
                    end
                    state_d = S_NEXT;
                end else begin
                    state_d = (state_q == S_CHK_DES) ? S_REQ_CUR : S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_COLL;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_REQ_DES;
                end
            end
            S_COLL: begin
                for (int g = 1; g < NUM_CHARS; g++) begin
                    collide_d[g-1] = (pos_x_q[g] == pos_x_q[0]) && (pos_y_q[g] == pos_y_q[0]);
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            collide_q  <= '0;
            tgt_x_q    <= '0;
            tgt_y_q    <= '0;
            cand_dir_q <= '0;
            for (int i = 0; i < NUM_CHARS; i++) begin
                pos_x_q[i] <= (i == 0) ? P_X0 : G_X0;
                pos_y_q[i] <= (i == 0) ? P_Y0 : G_Y0;
                dir_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            collide_q  <= collide_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            cand_dir_q <= cand_dir_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            dir_q      <= dir_d;
        end
    end

    // map_x/map_y show the live candidate while querying, else the last query.
    assign map_x        = map_req ? cand_x[COORD_W-1:0] : tgt_x_q;
    assign map_y        = map_req ? cand_y[COORD_W-1:0] : tgt_y_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
    assign collide_mask = collide_q;

    for (genvar i = 0; i < NUM_CHARS; i++) begin : g_pack
        assign pos_x[COORD_W*i +: COORD_W] = pos_x_q[i];
        assign pos_y[COORD_W*i +: COORD_W] = pos_y_q[i];
        assign dir[2*i +: 2]               = dir_q[i];
    end

endmodule

// File: tb/tb_char_move_engine.sv
// Bench for char_move_engine: frame-level reference model plus directed and random scenarios.
module tb_char_move_engine;
    localparam int NC = 5;
    localparam int CW = 5;
    localparam int GW = 28;
    localparam int GH = 28;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              tick = 1'b0;
    logic [2*NC-1:0]   desired_dir = '0;
    logic              load_we = 1'b0;
    logic [2:0]        load_idx = '0;
    logic [CW-1:0]     load_x = '0;
    logic [CW-1:0]     load_y = '0;
    logic [1:0]        load_dir = '0;
    logic              map_req;
    logic [CW-1:0]     map_x, map_y;
    logic              map_wall = 1'b0;
    logic [CW*NC-1:0]  pos_x, pos_y;
    logic [2*NC-1:0]   dir;
    logic              busy, done, overrun;
    logic [NC-2:0]     collide_mask;

    char_move_engine #(
        .NUM_CHARS(NC), .COORD_W(CW), .GRID_W(GW), .GRID_H(GH),
        .PLAYER_X0(2), .PLAYER_Y0(2), .GHOST_X0(27), .GHOST_Y0(27)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .desired_dir(desired_dir),
        .load_we(load_we), .load_idx(load_idx), .load_x(load_x), .load_y(load_y),
        .load_dir(load_dir), .map_req(map_req), .map_x(map_x), .map_y(map_y),
        .map_wall(map_wall), .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .busy(busy),
        .done(done), .collide_mask(collide_mask), .overrun(overrun)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int            mx [NC];
    int            my [NC];
    int            mdir [NC];
    logic [NC-2:0] m_coll;
    bit            m_ovr;
    int            m_lastx, m_lasty;
    bit            wall [32][32];
    bit            exp_req [64];
    int            exp_qx [64];
    int            exp_qy [64];
    int            done_off;
    bit            frame_on = 0;
    bit            frame_start = 0;
    int            off = 0;
    int            mt;
    bit            mok;
    int            n_done = 0;
    int            last_lat = 0;

    task automatic chk(input bit ok, input string name, input int act, input int expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int px(input int i);
        return int'(pos_x[CW*i +: CW]);
    endfunction
    function automatic int py(input int i);
        return int'(pos_y[CW*i +: CW]);
    endfunction
    function automatic int pd(input int i);
        return int'(dir[2*i +: 2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            mx[i]   = (i == 0) ? 2 : 27;
            my[i]   = (i == 0) ? 2 : 27;
            mdir[i] = 0;
        end
        m_coll      = '0;
        m_ovr       = 0;
        m_lastx     = 0;
        m_lasty     = 0;
        frame_on    = 0;
        frame_start = 0;
    endtask

    task automatic model_load(input int i, input int x, input int y, input int d);
        if (i < NC) begin
            mx[i] = x; my[i] = y; mdir[i] = d;
        end
    endtask

    // One move attempt for char i in direction d; advances the frame timeline mt.
    task automatic try_move(input int i, input int d);
        int nx, ny;
        nx = mx[i];
        ny = my[i];
        case (d)
            0: ny = ny - 1;
            1: nx = nx - 1;
            2: ny = ny + 1;
            default: nx = nx + 1;
        endcase
`ifdef TUNNEL_WRAP_EN
        if (d == 1 && mx[i] == 1) nx = GW - 1;
        if (d == 3 && mx[i] == GW - 1) nx = 1;
`endif
        if (nx < 1 || nx > GW - 1 || ny < 1 || ny > GH - 1) begin
            mt  = mt + 1;
            mok = 0;
        end else begin
            exp_req[mt] = 1;
            exp_qx[mt]  = nx;
            exp_qy[mt]  = ny;
            mt  = mt + 2;
            mok = !wall[nx][ny];
            if (mok) begin
                mx[i] = nx;
                my[i] = ny;
            end
        end
    endtask

    task automatic model_frame(input logic [2*NC-1:0] des);
        int dd;
        for (int k = 0; k < 64; k++) exp_req[k] = 0;
        mt = 1;
        for (int i = 0; i < NC; i++) begin
            dd = int'(des[2*i +: 2]);
            try_move(i, dd);
            if (mok) mdir[i] = dd;
            else try_move(i, mdir[i]);
            mt = mt + 1;
        end
        for (int g = 1; g < NC; g++)
            m_coll[g-1] = (mx[g] == mx[0]) && (my[g] == my[0]);
        done_off = mt + 1;
    endtask

    task automatic check_state();
        for (int i = 0; i < NC; i++) begin
            chk(px(i) == mx[i], "pos_x", px(i), mx[i]);
            chk(py(i) == my[i], "pos_y", py(i), my[i]);
            chk(pd(i) == mdir[i], "dir", pd(i), mdir[i]);
        end
        chk(collide_mask == m_coll, "collide_mask", int'(collide_mask), int'(m_coll));
    endtask

    // per-cycle compare against the model timeline
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (done) n_done++;
            if (frame_start) begin
                frame_start = 0;
                frame_on    = 1;
                off         = 0;
                chk(busy == 0, "busy_tick_cycle", busy, 0);
                chk(map_req == 0, "map_req_tick_cycle", map_req, 0);
            end else if (frame_on) begin
                off++;
                chk(map_req == exp_req[off], "map_req", map_req, exp_req[off]);
                if (exp_req[off]) begin
                    m_lastx = exp_qx[off];
                    m_lasty = exp_qy[off];
                end
                chk(int'(map_x) == m_lastx, "map_x", map_x, m_lastx);
                chk(int'(map_y) == m_lasty, "map_y", map_y, m_lasty);
                chk(busy == 1, "busy_frame", busy, 1);
                chk(done == (off == done_off), "done", done, off == done_off);
                if (off == done_off) begin
                    check_state();
                    last_lat = off;
                    frame_on = 0;
                end else if (off >= 63) begin
                    chk(0, "frame_overlong", off, done_off);
                    frame_on = 0;
                end
            end else begin
                chk(busy == 0, "busy_idle", busy, 0);
                chk(done == 0, "done_idle", done, 0);
                chk(map_req == 0, "map_req_idle", map_req, 0);
                chk(int'(map_x) == m_lastx, "map_x_hold", map_x, m_lastx);
                chk(int'(map_y) == m_lasty, "map_y_hold", map_y, m_lasty);
                check_state();
            end
            chk(overrun == m_ovr, "overrun", overrun, m_ovr);
        end
    end

    // wall map responder: answer one cycle after each query, noise otherwise
    initial begin
        bit pend, pw;
        forever begin
            @(negedge clk);
            pend = map_req;
            pw   = map_req ? wall[map_x][map_y] : 1'b0;
            @(posedge clk);
            #1;
            map_wall = pend ? pw : 1'($urandom_range(0, 1));
        end
    end

    // one clock cycle of stimulus
    task automatic step(input bit t, input bit lw, input int li, input int x, input int y, input int d);
        bit idle;
        @(posedge clk);
        #1;
        tick     = t;
        load_we  = lw;
        load_idx = 3'(li);
        load_x   = CW'(x);
        load_y   = CW'(y);
        load_dir = 2'(d);
        idle     = !frame_on;
        if (idle && t) begin
            if (lw) model_load(li, x, y, d);
            model_frame(desired_dir);
            frame_start = 1;
        end
        @(posedge clk);
        #1;
        tick    = 0;
        load_we = 0;
        if (idle && lw && !t) model_load(li, x, y, d);
        if (!idle && t) m_ovr = 1;
        // step consumed the next edge's setup slot; give it back as an idle cycle boundary
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_frame();
        int n = 0;
        while (frame_on && n < 200) begin
            idle_step();
            n++;
        end
        if (frame_on) begin
            chk(0, "frame_timeout", n, 200);
            frame_on = 0;
        end
    endtask

    task automatic run_frame(input logic [2*NC-1:0] des);
        desired_dir = des;
        step(1, 0, 0, 0, 0, 0);
        wait_frame();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1; tick = 0; load_we = 0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic clear_walls();
        for (int a = 0; a < 32; a++)
            for (int b = 0; b < 32; b++)
                wall[a][b] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 2_000_000);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [2*NC-1:0] des;
        clear_walls();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        // reset values pinned as literals
        chk(px(0) == 2 && py(0) == 2, "reset_player_pos", px(0) * 100 + py(0), 202);
        chk(px(3) == 27 && py(3) == 27, "reset_ghost_pos", px(3) * 100 + py(3), 2727);
        chk(dir == '0, "reset_dir", int'(dir), 0);
        chk({busy, done, map_req, overrun} == 4'b0, "reset_flags", {busy, done, map_req, overrun}, 0);

        // open map, everyone wants right; ghosts fall back to up
        run_frame({NC{2'd3}});
        chk(px(0) == 3 && py(0) == 2, "f1_player", px(0) * 100 + py(0), 302);
        chk(pd(0) == 3, "f1_player_dir", pd(0), 3);
        chk(px(1) == 27 && py(1) == 26, "f1_ghost1", px(1) * 100 + py(1), 2726);
        chk(last_lat == 21, "f1_latency", last_lat, 21);
        chk(collide_mask == 0, "f1_collide", int'(collide_mask), 0);

        // desired blocked by wall, fallback down succeeds
        step(0, 1, 0, 5, 5, 2);
        wall[4][5] = 1;
        run_frame(10'b00_00_00_00_01);
        chk(px(0) == 5 && py(0) == 6 && pd(0) == 2, "wall_fallback", px(0) * 1000 + py(0) * 10 + pd(0), 5062);

        // both candidates blocked
        step(0, 1, 0, 5, 5, 2);
        wall[5][6] = 1;
        n0 = n_done;
        run_frame(10'b00_00_00_00_01);
        chk(px(0) == 5 && py(0) == 5 && pd(0) == 2, "both_blocked", px(0) * 1000 + py(0) * 10 + pd(0), 5052);
        chk(n_done - n0 == 1, "both_blocked_done", n_done - n0, 1);

        // swap through each other, no collision
        clear_walls();
        step(0, 1, 1, 20, 20, 0);
        step(0, 1, 3, 20, 22, 0);
        step(0, 1, 4, 22, 22, 0);
        step(0, 1, 2, 6, 5, 1);
        step(0, 1, 0, 5, 5, 0);
        run_frame(10'b00_00_01_00_11);
        chk(px(0) == 6 && py(0) == 5, "swap_player", px(0) * 100 + py(0), 605);
        chk(px(2) == 5 && py(2) == 5, "swap_ghost2", px(2) * 100 + py(2), 505);
        chk(collide_mask[1] == 0, "swap_collide", collide_mask[1], 0);
        wall[6][4] = 1; wall[5][4] = 1; wall[7][5] = 1; wall[4][5] = 1;
        run_frame(10'b00_00_00_00_00);
        chk(px(0) == 6 && px(2) == 5, "blocked_still", px(0) * 100 + px(2), 605);
        chk(collide_mask[1] == 0, "blocked_collide", collide_mask[1], 0);
        step(0, 1, 2, 6, 5, 1);
        wall[5][5] = 1;
        run_frame(10'b00_00_00_00_00);
        chk(collide_mask == 4'b0010, "collide_hit", int'(collide_mask), 2);

        // tick while busy
        clear_walls();
        n0 = n_done;
        desired_dir = '0;
        step(1, 0, 0, 0, 0, 0);
        repeat (3) idle_step();
        step(1, 0, 0, 0, 0, 0);
        wait_frame();
        chk(overrun == 1, "overrun_set", overrun, 1);
        chk(n_done - n0 == 1, "overrun_one_done", n_done - n0, 1);

        // reset mid-frame
        step(1, 0, 0, 0, 0, 0);
        repeat (5) idle_step();
        do_reset();
        chk(px(0) == 2 && py(0) == 2 && px(2) == 27 && py(2) == 27, "midreset_pos",
            px(0) * 1000 + px(2), 2027);
        chk({busy, done, map_req, overrun} == 4'b0, "midreset_flags", {busy, done, map_req, overrun}, 0);
        chk(collide_mask == 0, "midreset_collide", int'(collide_mask), 0);

        // left edge: wrap or fallback
        step(0, 1, 0, 1, 14, 0);
        run_frame(10'b00_00_00_00_01);
`ifdef TUNNEL_WRAP_EN
        chk(px(0) == 27 && py(0) == 14 && pd(0) == 1, "tunnel_wrap", px(0) * 1000 + py(0) * 10 + pd(0), 27141);
`else
        chk(px(0) == 1 && py(0) == 13 && pd(0) == 0, "tunnel_off", px(0) * 1000 + py(0) * 10 + pd(0), 1130);
`endif

        // randomized frames
        for (int f = 0; f < 150; f++) begin
            for (int a = 0; a < 32; a++)
                for (int b = 0; b < 32; b++)
                    wall[a][b] = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2))
                step(0, 1, $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3));
            des = 10'($urandom);
            desired_dir = des;
            if ($urandom_range(0, 3) == 0)
                step(1, 1, $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3));
            else
                step(1, 0, 0, 0, 0, 0);
            if ($urandom_range(0, 2) == 0)
                step(0, 1, $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0)
                step(1, 0, 0, 0, 0, 0);
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(0, 6)) idle_step();
                do_reset();
            end
            wait_frame();
            idle_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
